shift_pipe_stage: RTL and testbench

- Two-stage pipelined shift unit, valid/ready handshake on both sides.
- Stage 1 registers the operand X, the shift amount S and the op code.
- Stage 2 computes the shift combinationally from the stage-1 registers and registers the result, zero flag and a retired-operation count.
- Sits between the ALU operand-issue logic and the writeback mux. It is the clocked shell around the 32-bit shifters (SLL/SRL/SRA/ROR).

---
 rtl/shift_pipe_stage.sv | 166 ++++++++++++++++
 tb/tb_shift_pipe_stage.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_pipe_stage.sv
// Two-stage pipelined 32-bit shift unit (SLL/SRL/SRA/ROR) between operand issue and writeback.
// Latency: 2 cycles from input transfer to out_valid; throughput 1 op/cycle with out_ready high.
// Backpressure: stage 2 holds while out_valid && !out_ready; stage 1 fills once, then in_ready drops.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    upstream handshake; in_x operand, in_s shift amount ([4:0] used), in_op code
//   out_valid/out_ready  downstream handshake; out_z result, out_zero (out_z == 0), out_op
//   retired              wrapping count of output transfers

module shift_pipe_stage #(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_x,
    input  logic [W-1:0]     in_s,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_z,
    output logic             out_zero,
    output logic [1:0]       out_op,
    output logic [CNT_W-1:0] retired
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    // ------------------------------------------------------------------
    // Shifter datapath
    // ------------------------------------------------------------------

    function automatic logic [31:0] bit_rev(input logic [31:0] v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    // One log-stage right shifter serves all four ops: SLL runs through it
    // bit-reversed, SRA fills from the sign bit, ROR wraps the low bits back
    // in at the top. sh == 0 passes x through for every op.
    function automatic logic [31:0] shift_f(input logic [31:0] x,
                                            input logic [4:0]  sh,
                                            input logic [1:0]  op);
        logic [31:0] d;
        logic [31:0] fill_mask;
        logic        fill;
        logic        rot;
        rot  = (op == OP_ROR);
        fill = (op == OP_SRA) && x[31];
        d    = (op == OP_SLL) ? bit_rev(x) : x;
        for (int k = 0; k < 5; k++) begin
            if (sh[k]) begin
                // Top 2^k bits vacated by this stage.
                fill_mask = ~(32'hFFFF_FFFF >> (1 << k));
                if (rot) begin
                    d = (d >> (1 << k)) | (d << (32 - (1 << k)));
                end else begin
                    d = (d >> (1 << k)) | (fill ? fill_mask : 32'h0);
                end
            end
        end
        if (op == OP_SLL) begin
            d = bit_rev(d);
        end
        return d;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------

    logic             s1_valid_q;
    logic [W-1:0]     s1_x_q;
    logic [4:0]       s1_sh_q;
    logic [1:0]       s1_op_q;

    logic             out_valid_q;
    logic [W-1:0]     out_z_q;
    logic             out_zero_q;
    logic [1:0]       out_op_q;
    logic [CNT_W-1:0] retired_q;

    // Next-state values computed from stage 1.
    logic [W-1:0]     out_z_d;
    logic             out_zero_d;
    logic [CNT_W-1:0] retired_d;

    // Handshake terms
    logic s2_adv;
    logic s1_adv;
    logic in_xfer;
    logic out_xfer;

    // Upper shift-amount bits are architecturally ignored.
    logic unused_s_hi;
    assign unused_s_hi = ^in_s[W-1:5];

    // Stage 2 can take a new value whenever it is empty or being drained.
    // Stage 1 moves in lockstep with it. in_ready depends only on pipeline
    // state and out_ready, never on in_valid.
    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = s2_adv;
    assign in_ready = !s1_valid_q || s2_adv;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid_q && out_ready;

    always_comb begin
        out_z_d    = shift_f(s1_x_q, s1_sh_q, s1_op_q);
        out_zero_d = (out_z_d == '0);
        retired_d  = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // In-flight items are dropped and never counted.
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_z_q     <= '0;
            out_zero_q  <= 1'b0;
            out_op_q    <= 2'b00;
            retired_q   <= '0;
        end else begin
            // Stage 2: advance, or hold everything while stalled.
            if (s2_adv) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_z_q    <= out_z_d;
                    out_zero_q <= out_zero_d;
                    out_op_q   <= s1_op_q;
                end
            end

            // Stage 1: refill on accept (even while stage 2 drains, so no
            // bubble), otherwise empty out once its content moved on.
            if (in_xfer) begin
                s1_valid_q <= 1'b1;
                s1_x_q     <= in_x;
                s1_sh_q    <= in_s[4:0];
                s1_op_q    <= in_op;
            end else if (s1_adv) begin
                s1_valid_q <= 1'b0;
            end

            if (out_xfer) begin
                retired_q <= retired_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_z     = out_z_q;
    assign out_zero  = out_zero_q;
    assign out_op    = out_op_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_shift_pipe_stage.sv
// Directed bench for shift_pipe_stage, built with a 4-bit retire counter so wrap is reachable.
// Inputs are driven 1 time unit after each rising edge; outputs are sampled at that same point.
// Expected values are hand-computed constants per vector.

module tb_shift_pipe_stage;

    localparam int W     = 32;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_x;
    logic [W-1:0]     in_s;
    logic [1:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_z;
    logic             out_zero;
    logic [1:0]       out_op;
    logic [CNT_W-1:0] retired;

    int checks;
    int errors;
    int ret_exp;

    // Vector table used by the streaming routine.
    logic [31:0] vx   [0:31];
    logic [31:0] vs   [0:31];
    logic [1:0]  vop  [0:31];
    logic [31:0] vexp [0:31];

    shift_pipe_stage #(.W(W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_s      (in_s),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_z     (out_z),
        .out_zero  (out_zero),
        .out_op    (out_op),
        .retired   (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [31:0] x, input logic [31:0] s,
                           input logic [1:0] op, input logic [31:0] e);
        vx[i] = x; vs[i] = s; vop[i] = op; vexp[i] = e;
    endtask

    task automatic drive(input int i);
        in_valid = 1'b1;
        in_x     = vx[i];
        in_s     = vs[i];
        in_op    = vop[i];
    endtask

    task automatic chk_result(input string tag, input int i);
        chk({tag, "_valid"}, 32'(out_valid), 32'h1);
        chk({tag, "_z"},     out_z,          vexp[i]);
        chk({tag, "_zero"},  32'(out_zero),  32'(vexp[i] == 32'h0));
        chk({tag, "_op"},    32'(out_op),    32'(vop[i]));
    endtask

    // Back-to-back stream with out_ready held high: item i is accepted at
    // one edge and must be on the outputs right after the following edge.
    task automatic run_stream(input string tag, input int n);
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            drive(i);
            chk({tag, "_in_ready"}, 32'(in_ready), 32'h1);
            tick();
            if (i == 0) chk({tag, "_lat_not_early"}, 32'(out_valid), 32'h0);
            else        chk_result(tag, i - 1);
        end
        in_valid = 1'b0;
        tick();
        chk_result(tag, n - 1);
        tick();
        ret_exp = ret_exp + n;
        chk({tag, "_drained"}, 32'(out_valid), 32'h0);
        chk({tag, "_retired"}, 32'(retired), 32'(ret_exp % 16));
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        ret_exp   = 0;
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_x      = 32'hDEAD_BEEF;
        in_s      = 32'h3;
        in_op     = 2'b01;
        out_ready = 1'b1;

        // ---------------- Reset held 2 edges with in_valid high ----------
        tick();
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_z",     out_z,          32'h0);
        chk("rst_out_zero",  32'(out_zero),  32'h0);
        chk("rst_out_op",    32'(out_op),    32'h0);
        chk("rst_retired",   32'(retired),   32'h0);
        chk("rst_in_ready",  32'(in_ready),  32'h1);
        tick();
        chk("rst_no_capture", 32'(out_valid), 32'h0);

        // ---------------- All four ops on X=0x80000F00, S=4 ---------------
        set_vec(0, 32'h8000_0F00, 32'h4, 2'b00, 32'h0000_F000);
        set_vec(1, 32'h8000_0F00, 32'h4, 2'b01, 32'h0800_00F0);
        set_vec(2, 32'h8000_0F00, 32'h4, 2'b10, 32'hF800_00F0);
        set_vec(3, 32'h8000_0F00, 32'h4, 2'b11, 32'h0800_00F0);
        run_stream("ops", 4);

        // ---------------- Shift-amount masking and edge amounts -----------
        set_vec(0, 32'hFFFF_FFFF, 32'h0000_0021, 2'b01, 32'h7FFF_FFFF);
        set_vec(1, 32'h0000_0001, 32'h0000_0020, 2'b00, 32'h0000_0001);
        set_vec(2, 32'h0000_0001, 32'h0000_0001, 2'b01, 32'h0000_0000);
        set_vec(3, 32'h0000_0001, 32'hFFFF_FFE1, 2'b11, 32'h8000_0000);
        set_vec(4, 32'h4000_0000, 32'h0000_001F, 2'b10, 32'h0000_0000);
        set_vec(5, 32'h8000_0001, 32'h0000_001F, 2'b00, 32'h8000_0000);
        run_stream("mask", 6);

        // ---------------- Backpressure ------------------------------------
        set_vec(0, 32'h1234_5678, 32'd8,  2'b11, 32'h7812_3456);
        set_vec(1, 32'h0000_00FF, 32'd4,  2'b00, 32'h0000_0FF0);
        set_vec(2, 32'h8000_0000, 32'd31, 2'b10, 32'hFFFF_FFFF);
        set_vec(3, 32'hF000_0000, 32'd28, 2'b01, 32'h0000_000F);
        out_ready = 1'b1;
        drive(0);
        tick();                       // A accepted
        out_ready = 1'b0;
        drive(1);
        chk("bp_accept_b", 32'(in_ready), 32'h1);
        tick();                       // B accepted, A on outputs
        drive(2);
        chk("bp_ready_low", 32'(in_ready), 32'h0);
        chk_result("bp_first", 0);
        tick();                       // stalled
        chk("bp_ready_low2", 32'(in_ready), 32'h0);
        chk_result("bp_hold1", 0);
        tick();                       // still stalled
        chk_result("bp_hold2", 0);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_release", 32'(in_ready), 32'h1);
        tick();                       // A handed off, B out, C accepted
        chk_result("bp_b", 1);
        drive(3);
        tick();                       // C out, D accepted
        chk_result("bp_c", 2);
        in_valid = 1'b0;
        tick();
        chk_result("bp_d", 3);
        tick();
        ret_exp = ret_exp + 4;
        chk("bp_drained", 32'(out_valid), 32'h0);
        chk("bp_retired", 32'(retired), 32'(ret_exp % 16));

        // ---------------- Reset with two items in flight ------------------
        set_vec(0, 32'hAAAA_0000, 32'd1, 2'b01, 32'h5555_0000);
        set_vec(1, 32'h0000_0003, 32'd2, 2'b00, 32'h0000_000C);
        out_ready = 1'b0;
        drive(0);
        tick();
        drive(1);
        tick();
        chk("mid_out_valid_pre", 32'(out_valid), 32'h1);
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        chk("mid_out_valid", 32'(out_valid), 32'h0);
        chk("mid_retired",   32'(retired),   32'h0);
        chk("mid_in_ready",  32'(in_ready),  32'h1);
        out_ready = 1'b1;
        tick();
        chk("mid_s1_flushed", 32'(out_valid), 32'h0);
        ret_exp = 0;
        set_vec(0, 32'h0F0F_0F0F, 32'd4, 2'b11, 32'hF0F0_F0F0);
        run_stream("post_rst", 1);

        // ---------------- Counter wrap: 17 transfers from zero ------------
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ret_exp = 0;
        for (int i = 0; i < 17; i++) begin
            // S=0 with nonzero ignored upper bits: every op returns X.
            set_vec(i, 32'(i), 32'hFFFF_FFE0, 2'(i), 32'(i));
        end
        run_stream("wrap", 17);
        chk("wrap_retired_is_1", 32'(retired), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
